// File: rtl/serv_rf_dbg_arb.sv
// Debug halt controller: parks serv at an RF read boundary, then lends the RF RAM port to a debug host.
// Host access latency is cyc->ack in 3 cycles; the withheld CPU read request is replayed on resume.
module serv_rf_dbg_arb #(
   parameter int RF_WIDTH     = 8,
   parameter int CSR_REGS     = 4,
   parameter int RF_L2D       = $clog2((32+CSR_REGS)*32/RF_WIDTH),
   parameter int DRAIN_CYCLES = 8
) (
   input  logic                clk,
   input  logic                i_rst,
   input  logic                i_cpu_rreq,
   output logic                o_cpu_ready,
   output logic                o_ifc_rreq,
   input  logic                i_ifc_ready,
   input  logic [RF_L2D-1:0]   i_ifc_waddr,
   input  logic [RF_WIDTH-1:0] i_ifc_wdata,
   input  logic                i_ifc_wen,
   input  logic [RF_L2D-1:0]   i_ifc_raddr,
   input  logic                i_ifc_ren,
   output logic [RF_WIDTH-1:0] o_ifc_rdata,
   output logic [RF_L2D-1:0]   o_ram_waddr,
   output logic [RF_WIDTH-1:0] o_ram_wdata,
   output logic                o_ram_wen,
   output logic [RF_L2D-1:0]   o_ram_raddr,
   output logic                o_ram_ren,
   input  logic [RF_WIDTH-1:0] i_ram_rdata,
   input  logic                i_dbg_halt_req,
   output logic                o_dbg_halted,
   input  logic                i_dbg_cyc,
   input  logic                i_dbg_we,
   input  logic [RF_L2D-1:0]   i_dbg_adr,
   input  logic [RF_WIDTH-1:0] i_dbg_dat,
   output logic [RF_WIDTH-1:0] o_dbg_rdt,
   output logic                o_dbg_ack
);

   localparam int DEPTH = (32+CSR_REGS)*32/RF_WIDTH;
   localparam logic [RF_L2D:0] DEPTH_W   = (RF_L2D+1)'(DEPTH);
   localparam logic [7:0]      DRAIN_INIT = 8'(DRAIN_CYCLES);

   typedef enum logic [2:0] {
      S_RUN, S_DRAIN, S_HALT, S_ACC, S_CAP, S_ACK, S_RESUME
   } state_t;

   state_t                state_q, state_d;
   logic                  pend_q, pend_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [RF_L2D-1:0]     adr_q, adr_d;
   logic                  we_q, we_d;
   logic [RF_WIDTH-1:0]   dat_q, dat_d;
   logic [RF_WIDTH-1:0]   rdt_q, rdt_d;
   logic                  host_sel;
   logic                  in_range;

   assign in_range = {1'b0, adr_q} < DEPTH_W;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= S_RUN;
         pend_q  <= 1'b0;
         cnt_q   <= DRAIN_INIT;
         adr_q   <= '0;
         we_q    <= 1'b0;
         dat_q   <= '0;
         rdt_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         dat_q   <= dat_d;
         rdt_q   <= rdt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      adr_d       = adr_q;
      we_d        = we_q;
      dat_d       = dat_q;
      rdt_d       = rdt_q;
      o_ifc_rreq  = 1'b0;
      o_cpu_ready = 1'b0;
      o_dbg_ack   = 1'b0;
      host_sel    = 1'b0;
      case (state_q)
         S_RUN: begin
            o_ifc_rreq  = i_cpu_rreq;
            o_cpu_ready = i_ifc_ready;
            // Withhold the read so the CPU stalls at the instruction boundary
            if (i_cpu_rreq && i_dbg_halt_req) begin
               o_ifc_rreq = 1'b0;
               pend_d     = 1'b1;
               cnt_d      = DRAIN_INIT;
               state_d    = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!i_dbg_halt_req) begin
               state_d = S_RESUME;
            end else if (i_ifc_wen) begin
               cnt_d = DRAIN_INIT;
            end else begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_d == 8'd0) state_d = S_HALT;
            end
         end
         S_HALT: begin
            host_sel = 1'b1;
            if (i_dbg_cyc) begin
               adr_d   = i_dbg_adr;
               we_d    = i_dbg_we;
               dat_d   = i_dbg_dat;
               state_d = S_ACC;
            end else if (!i_dbg_halt_req) begin
               state_d = S_RESUME;
            end
         end
         S_ACC: begin
            host_sel = 1'b1;
            state_d  = S_CAP;
         end
         S_CAP: begin
            host_sel = 1'b1;
            if (!we_q) rdt_d = in_range ? i_ram_rdata : '0;
            state_d  = S_ACK;
         end
         S_ACK: begin
            host_sel  = 1'b1;
            o_dbg_ack = 1'b1;
            state_d   = S_HALT;
         end
         S_RESUME: begin
            o_ifc_rreq  = pend_q;
            o_cpu_ready = i_ifc_ready;
            pend_d      = 1'b0;
            state_d     = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
   end

   assign o_dbg_halted = host_sel;
   assign o_dbg_rdt    = rdt_q;
   assign o_ifc_rdata  = i_ram_rdata;
   assign o_ram_waddr  = host_sel ? adr_q : i_ifc_waddr;
   assign o_ram_wdata  = host_sel ? dat_q : i_ifc_wdata;
   assign o_ram_raddr  = host_sel ? adr_q : i_ifc_raddr;
   assign o_ram_wen    = host_sel ? (state_q == S_ACC) &&  we_q && in_range : i_ifc_wen;
   assign o_ram_ren    = host_sel ? (state_q == S_ACC) && !we_q && in_range : i_ifc_ren;

endmodule

// File: tb/tb_serv_rf_dbg_arb.sv
// Directed bench for serv_rf_dbg_arb with a small behavioural RF RAM behind the RAM port.
module tb_serv_rf_dbg_arb;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_cpu_rreq, o_cpu_ready, o_ifc_rreq, i_ifc_ready;
   logic [7:0] i_ifc_waddr, i_ifc_wdata, i_ifc_raddr, o_ifc_rdata;
   logic       i_ifc_wen, i_ifc_ren;
   logic [7:0] o_ram_waddr, o_ram_wdata, o_ram_raddr, i_ram_rdata;
   logic       o_ram_wen, o_ram_ren;
   logic       i_dbg_halt_req, o_dbg_halted, i_dbg_cyc, i_dbg_we, o_dbg_ack;
   logic [7:0] i_dbg_adr, i_dbg_dat, o_dbg_rdt;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] mem [0:143];

   always #5 clk = ~clk;

   serv_rf_dbg_arb dut (
      .clk(clk), .i_rst(i_rst),
      .i_cpu_rreq(i_cpu_rreq), .o_cpu_ready(o_cpu_ready),
      .o_ifc_rreq(o_ifc_rreq), .i_ifc_ready(i_ifc_ready),
      .i_ifc_waddr(i_ifc_waddr), .i_ifc_wdata(i_ifc_wdata), .i_ifc_wen(i_ifc_wen),
      .i_ifc_raddr(i_ifc_raddr), .i_ifc_ren(i_ifc_ren), .o_ifc_rdata(o_ifc_rdata),
      .o_ram_waddr(o_ram_waddr), .o_ram_wdata(o_ram_wdata), .o_ram_wen(o_ram_wen),
      .o_ram_raddr(o_ram_raddr), .o_ram_ren(o_ram_ren), .i_ram_rdata(i_ram_rdata),
      .i_dbg_halt_req(i_dbg_halt_req), .o_dbg_halted(o_dbg_halted),
      .i_dbg_cyc(i_dbg_cyc), .i_dbg_we(i_dbg_we), .i_dbg_adr(i_dbg_adr),
      .i_dbg_dat(i_dbg_dat), .o_dbg_rdt(o_dbg_rdt), .o_dbg_ack(o_dbg_ack)
   );

   // Behavioural serv_rf_ram: one-cycle read latency, 144 words
   always @(posedge clk) begin
      if (o_ram_wen && int'(o_ram_waddr) < 144) mem[o_ram_waddr] <= o_ram_wdata;
      if (o_ram_ren) i_ram_rdata <= (int'(o_ram_raddr) < 144) ? mem[o_ram_raddr] : 8'h00;
   end

   task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic host_acc(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                           input logic exp_wen, input logic exp_ren, input logic [7:0] exp_rdt);
      tick;
      i_dbg_cyc = 1'b1; i_dbg_we = we; i_dbg_adr = adr; i_dbg_dat = dat;
      settle;
      check_vec("acc_t0_ack", 32'(o_dbg_ack), 32'd0);
      tick;
      i_dbg_cyc = 1'b0;
      settle;
      check_vec("acc_t1_wen", 32'(o_ram_wen), 32'(exp_wen));
      check_vec("acc_t1_ren", 32'(o_ram_ren), 32'(exp_ren));
      if (exp_wen) check_vec("acc_t1_wr", 32'({o_ram_waddr, o_ram_wdata}), 32'({adr, dat}));
      if (exp_ren) check_vec("acc_t1_raddr", 32'(o_ram_raddr), 32'(adr));
      check_vec("acc_t1_ack", 32'(o_dbg_ack), 32'd0);
      tick;
      settle;
      check_vec("acc_t2_ack", 32'(o_dbg_ack), 32'd0);
      check_vec("acc_t2_wen", 32'(o_ram_wen), 32'd0);
      tick;
      settle;
      check_vec("acc_t3_ack", 32'(o_dbg_ack), 32'd1);
      check_vec("acc_t3_rdt", 32'(o_dbg_rdt), 32'(exp_rdt));
      tick;
      settle;
      check_vec("acc_t4_ack", 32'(o_dbg_ack), 32'd0);
      check_vec("acc_t4_halted", 32'(o_dbg_halted), 32'd1);
   endtask

   initial begin
      i_rst = 1'b1; i_cpu_rreq = 1'b0; i_ifc_ready = 1'b0;
      i_ifc_waddr = '0; i_ifc_wdata = '0; i_ifc_wen = 1'b0;
      i_ifc_raddr = '0; i_ifc_ren = 1'b0; i_ram_rdata = '0;
      i_dbg_halt_req = 1'b0; i_dbg_cyc = 1'b0; i_dbg_we = 1'b0;
      i_dbg_adr = '0; i_dbg_dat = '0;
      for (int i = 0; i < 144; i++) mem[i] = 8'h00;

      tick; tick;
      settle;
      check_vec("rst_halted", 32'(o_dbg_halted), 32'd0);
      check_vec("rst_ack", 32'(o_dbg_ack), 32'd0);
      check_vec("rst_rdt", 32'(o_dbg_rdt), 32'd0);
      check_vec("rst_ifc_rreq", 32'(o_ifc_rreq), 32'd0);
      i_rst = 1'b0;

      // Pass-through with no halt request
      for (int i = 0; i < 100; i++) begin
         tick;
         i_cpu_rreq  = 1'($urandom);
         i_ifc_ready = 1'($urandom);
         i_ifc_waddr = 8'($urandom);
         i_ifc_wdata = 8'($urandom);
         i_ifc_wen   = 1'($urandom);
         i_ifc_raddr = 8'($urandom);
         i_ifc_ren   = 1'($urandom);
         settle;
         check_vec("run_rreq", 32'(o_ifc_rreq), 32'(i_cpu_rreq));
         check_vec("run_ready", 32'(o_cpu_ready), 32'(i_ifc_ready));
         check_vec("run_ram_mux",
                   32'({o_ram_waddr, o_ram_wdata, o_ram_wen, o_ram_raddr, o_ram_ren}),
                   32'({i_ifc_waddr, i_ifc_wdata, i_ifc_wen, i_ifc_raddr, i_ifc_ren}));
         check_vec("run_rdata", 32'(o_ifc_rdata), 32'(i_ram_rdata));
         check_vec("run_halted", 32'(o_dbg_halted), 32'd0);
      end

      // Host access while running is ignored
      tick;
      i_cpu_rreq = 1'b0; i_ifc_wen = 1'b0; i_ifc_ren = 1'b0; i_ifc_ready = 1'b0;
      i_dbg_cyc = 1'b1; i_dbg_we = 1'b1; i_dbg_adr = 8'h0A; i_dbg_dat = 8'h33;
      for (int i = 0; i < 4; i++) begin
         tick;
         settle;
         check_vec("run_host_ack", 32'(o_dbg_ack), 32'd0);
         check_vec("run_host_wen", 32'(o_ram_wen), 32'd0);
      end
      i_dbg_cyc = 1'b0;

      // Halt request alone waits for the next rreq
      tick;
      i_dbg_halt_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         settle;
         check_vec("hreq_only_halted", 32'(o_dbg_halted), 32'd0);
      end
      tick;
      i_cpu_rreq = 1'b1; i_ifc_ready = 1'b1;
      settle;
      check_vec("halt_rreq_blocked", 32'(o_ifc_rreq), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         tick;
         i_cpu_rreq = 1'b0;
         i_ifc_wen = (k <= 2);
         i_ifc_waddr = 8'(k);
         settle;
         check_vec("drain_halted", 32'(o_dbg_halted), 32'd0);
         check_vec("drain_ready", 32'(o_cpu_ready), 32'd0);
         check_vec("drain_rreq", 32'(o_ifc_rreq), 32'd0);
         check_vec("drain_wen_mux", 32'(o_ram_wen), 32'(k <= 2));
      end
      tick;
      i_ifc_wen = 1'b0;
      settle;
      check_vec("halted_at_21", 32'(o_dbg_halted), 32'd1);
      check_vec("halted_ready", 32'(o_cpu_ready), 32'd0);

      host_acc(1'b1, 8'h0A, 8'h5C, 1'b1, 1'b0, 8'h00);
      host_acc(1'b0, 8'h0A, 8'h00, 1'b0, 1'b1, 8'h5C);
      host_acc(1'b0, 8'hA0, 8'h00, 1'b0, 1'b0, 8'h00);
      host_acc(1'b1, 8'hA0, 8'hFF, 1'b0, 1'b0, 8'h00);
      host_acc(1'b0, 8'h0A, 8'h00, 1'b0, 1'b1, 8'h5C);
      check_vec("mem_0a", 32'(mem[10]), 32'h5C);

      // Resume from HALT replays the withheld read exactly once
      tick;
      i_dbg_halt_req = 1'b0; i_ifc_ready = 1'b0;
      settle;
      check_vec("res_t0_halted", 32'(o_dbg_halted), 32'd1);
      check_vec("res_t0_rreq", 32'(o_ifc_rreq), 32'd0);
      tick;
      settle;
      check_vec("res_t1_rreq", 32'(o_ifc_rreq), 32'd1);
      check_vec("res_t1_halted", 32'(o_dbg_halted), 32'd0);
      tick;
      i_ifc_ready = 1'b1;
      settle;
      check_vec("res_t2_rreq", 32'(o_ifc_rreq), 32'd0);
      check_vec("res_t2_ready", 32'(o_cpu_ready), 32'd1);
      check_vec("res_t2_halted", 32'(o_dbg_halted), 32'd0);

      // Reset in the middle of a host access
      tick;
      i_ifc_ready = 1'b0; i_dbg_halt_req = 1'b1; i_cpu_rreq = 1'b1;
      tick;
      i_cpu_rreq = 1'b0;
      repeat (8) tick;
      settle;
      check_vec("rehalt_halted", 32'(o_dbg_halted), 32'd1);
      i_dbg_cyc = 1'b1; i_dbg_we = 1'b1; i_dbg_adr = 8'h03; i_dbg_dat = 8'h77;
      tick;
      i_dbg_cyc = 1'b0;
      settle;
      check_vec("midacc_wen", 32'(o_ram_wen), 32'd1);
      i_rst = 1'b1;
      tick;
      i_rst = 1'b0; i_dbg_halt_req = 1'b0;
      settle;
      check_vec("post_rst_halted", 32'(o_dbg_halted), 32'd0);
      check_vec("post_rst_ack", 32'(o_dbg_ack), 32'd0);
      check_vec("post_rst_rdt", 32'(o_dbg_rdt), 32'd0);
      check_vec("post_rst_rreq", 32'(o_ifc_rreq), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         settle;
         check_vec("post_rst_no_replay", 32'(o_ifc_rreq), 32'd0);
         check_vec("post_rst_no_ack", 32'(o_dbg_ack), 32'd0);
      end

      // Halt dropped while draining
      tick;
      i_dbg_halt_req = 1'b1; i_cpu_rreq = 1'b1;
      settle;
      check_vec("dd_rreq_blocked", 32'(o_ifc_rreq), 32'd0);
      tick;
      i_cpu_rreq = 1'b0; i_dbg_halt_req = 1'b0;
      settle;
      check_vec("dd_drain_rreq", 32'(o_ifc_rreq), 32'd0);
      check_vec("dd_drain_halted", 32'(o_dbg_halted), 32'd0);
      tick;
      settle;
      check_vec("dd_replay", 32'(o_ifc_rreq), 32'd1);
      tick;
      settle;
      check_vec("dd_after_replay", 32'(o_ifc_rreq), 32'd0);
      check_vec("dd_halted", 32'(o_dbg_halted), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
